// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int LANE_W            = 2;
  localparam int DEFAULT_MEM_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WAIT_WORD = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  // Little-endian byte select: lane 0 is bits [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [LANE_W-1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Word stream from the boot link plus the byte write port into instruction memory.
interface imem_loader_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_serializer.sv
// Holds one instruction word and presents its bytes lowest lane first, one per advance.
module word_byte_serializer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        advance,
  output logic [7:0]  byte_out,
  output logic        last_lane
);

  logic [31:0]       word_r;
  logic [LANE_W-1:0] lane_r;
  logic [7:0]        byte_r;
  logic [LANE_W-1:0] lane_inc_s;

  assign lane_inc_s = lane_r + LANE_W'(1);

  // byte_r is registered so the byte lines up with the registered write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= 32'h0000_0000;
      lane_r <= '0;
      byte_r <= 8'h00;
    end else if (load) begin
      word_r <= word_in;
      lane_r <= '0;
      byte_r <= lane_byte(word_in, LANE_W'(0));
    end else if (advance) begin
      word_r <= word_r;
      lane_r <= lane_inc_s;
      byte_r <= lane_byte(word_r, lane_inc_s);
    end else begin
      word_r <= word_r;
      lane_r <= lane_r;
      byte_r <= byte_r;
    end
  end

  assign byte_out  = byte_r;
  assign last_lane = (lane_r == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: accepts 32-bit words and writes them
// little-endian one byte per cycle, stalling the core while a session runs.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int ADDR_W    = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] cur_addr_r, cur_addr_next_s;
  logic [CNT_W-1:0]  remaining_r, remaining_next_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_next_s;
  logic              in_ready_r, in_ready_next_s;
  logic              mem_we_r, mem_we_next_s;
  logic              busy_r, busy_next_s;
  logic              done_r, done_next_s;
  logic              err_r, err_next_s;
  logic              accept_s, load_s, advance_s;
  logic              last_lane_s;
  logic [7:0]        byte_s;

  // One extra bit on the end address so a base near the top cannot wrap into range.
  function automatic logic word_fits(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] end_addr;
    end_addr = {1'b0, addr} + (ADDR_W+1)'(BYTES_PER_WORD);
    return (end_addr <= (ADDR_W+1)'(MEM_BYTES));
  endfunction

  assign accept_s = (state_r == WAIT_WORD) && bus.in_valid && in_ready_r;

  word_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .word_in   (bus.in_data),
    .advance   (advance_s),
    .byte_out  (byte_s),
    .last_lane (last_lane_s)
  );

  // Next-state, session bookkeeping and next values of the registered outputs
  always_comb begin
    state_next_s     = state_r;
    cur_addr_next_s  = cur_addr_r;
    remaining_next_s = remaining_r;
    mem_addr_next_s  = mem_addr_r;
    err_next_s       = err_r;
    load_s           = 1'b0;
    advance_s        = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          cur_addr_next_s  = base_addr;
          remaining_next_s = word_count;
          err_next_s       = 1'b0;
          state_next_s     = CHECK;
        end else begin
          state_next_s     = IDLE;
        end
      end
      CHECK: begin
        if (cur_addr_r[1:0] != 2'b00) begin
          err_next_s   = 1'b1;
          state_next_s = ERROR;
        end else if (remaining_r == {CNT_W{1'b0}}) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (!word_fits(cur_addr_r)) begin
          err_next_s   = 1'b1;
          state_next_s = ERROR;
        end else if (accept_s) begin
          load_s          = 1'b1;
          mem_addr_next_s = cur_addr_r;
          state_next_s    = WRITE;
        end else begin
          state_next_s    = WAIT_WORD;
        end
      end
      WRITE: begin
        if (last_lane_s) begin
          cur_addr_next_s  = cur_addr_r + ADDR_W'(BYTES_PER_WORD);
          remaining_next_s = remaining_r - CNT_W'(1);
          if (remaining_r == CNT_W'(1)) begin
            state_next_s = DONE;
          end else begin
            state_next_s = WAIT_WORD;
          end
        end else begin
          advance_s       = 1'b1;
          mem_addr_next_s = mem_addr_r + ADDR_W'(1);
          state_next_s    = WRITE;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      ERROR: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    in_ready_next_s = (state_next_s == WAIT_WORD) && word_fits(cur_addr_next_s);
    mem_we_next_s   = (state_next_s == WRITE);
    busy_next_s     = (state_next_s == CHECK) || (state_next_s == WAIT_WORD) ||
                      (state_next_s == WRITE);
    done_next_s     = (state_next_s == DONE);
  end

  // State, session registers and the registered output copies
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cur_addr_r  <= '0;
      remaining_r <= '0;
      mem_addr_r  <= '0;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cur_addr_r  <= cur_addr_next_s;
      remaining_r <= remaining_next_s;
      mem_addr_r  <= mem_addr_next_s;
      in_ready_r  <= in_ready_next_s;
      mem_we_r    <= mem_we_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
      err_r       <= err_next_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = byte_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule
